// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - shared types and constants for the hazard stall controller
//
// Purpose: FSM state encoding, the architectural zero register number and
//          the legal range of the mult/div occupancy parameter.
// Ports:   none (package).

package hazard_pkg;

  typedef enum logic {
    RUN  = 1'b0,
    BUSY = 1'b1
  } state_e;

  localparam logic [4:0] REG_ZERO = 5'd0;

  // Legal range of MULDIV_LATENCY. The 4-bit down-counter holds at most
  // MULDIV_LATENCY-2 = 14.
  localparam int MULDIV_LATENCY_MIN = 1;
  localparam int MULDIV_LATENCY_MAX = 16;

  // Forces an out-of-range latency into the legal window so the counter
  // load value always fits.
  function automatic int clamp_muldiv_latency(input int lat);
    if (lat < MULDIV_LATENCY_MIN) return MULDIV_LATENCY_MIN;
    if (lat > MULDIV_LATENCY_MAX) return MULDIV_LATENCY_MAX;
    return lat;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating up-counter
//
// Purpose: counts cycles where inc_in is high, holding at all-ones.
// Ports:
//   clk_in    - clock, rising edge
//   rst_n_in  - synchronous active-low reset, clears the count
//   inc_in    - increment request for this edge
//   count_out - current count (WIDTH bits)

module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk_in,
  input  logic             rst_n_in,
  input  logic             inc_in,
  output logic [WIDTH-1:0] count_out
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (inc_in && (count_q != {WIDTH{1'b1}})) begin
      count_d = count_q + {{(WIDTH-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_out = count_q;

endmodule

// File: rtl/hazard_stall_controller.sv
// rtl/hazard_stall_controller.sv - load-use / mult-div / branch pipeline sequencing
//
// Purpose: resolves hazards that forwarding cannot: inserts a load-use bubble,
//          holds the front of the pipe while a mult/div occupies EX, and
//          squashes IF/ID and ID/EX on a taken branch. Counts stall cycles.
// Ports:
//   clk_in, rst_n_in                    - clock, synchronous active-low reset
//   ID_EX_mem_read_in, ID_EX_RT_in      - load in EX and its destination
//   IF_ID_RS_in, IF_ID_RT_in,
//   IF_ID_uses_rt_in                    - source operands of the ID instruction
//   muldiv_start_in                     - EX instruction is mult/div
//   branch_taken_in                     - branch resolved taken in EX
//   PC_write_out, IF_ID_write_out,
//   ID_EX_write_out                     - pipeline register enables
//   ID_EX_bubble_out, EX_MEM_bubble_out - zero control bits on next edge
//   IF_ID_flush_out, ID_EX_flush_out    - squash controls
//   muldiv_busy_out                     - FSM in BUSY
//   stall_cycles_out                    - saturating count of PC hold cycles

module hazard_stall_controller
  import hazard_pkg::*;
#(
  parameter int MULDIV_LATENCY = 4,
  parameter int PERF_WIDTH     = 16
) (
  input  logic                  clk_in,
  input  logic                  rst_n_in,
  input  logic                  ID_EX_mem_read_in,
  input  logic [4:0]            ID_EX_RT_in,
  input  logic [4:0]            IF_ID_RS_in,
  input  logic [4:0]            IF_ID_RT_in,
  input  logic                  IF_ID_uses_rt_in,
  input  logic                  muldiv_start_in,
  input  logic                  branch_taken_in,
  output logic                  PC_write_out,
  output logic                  IF_ID_write_out,
  output logic                  ID_EX_write_out,
  output logic                  ID_EX_bubble_out,
  output logic                  EX_MEM_bubble_out,
  output logic                  IF_ID_flush_out,
  output logic                  ID_EX_flush_out,
  output logic                  muldiv_busy_out,
  output logic [PERF_WIDTH-1:0] stall_cycles_out
);

  localparam int LAT = clamp_muldiv_latency(MULDIV_LATENCY);
  // A one-cycle mult/div never needs to hold the pipe.
  localparam bit MULDIV_STALLS = (LAT >= 2);
  // The start cycle is the first stall; BUSY then stalls cnt more cycles
  // and releases when cnt reaches zero.
  localparam logic [3:0] CNT_LOAD = MULDIV_STALLS ? 4'(LAT - 2) : 4'd0;

  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       load_use;
  logic       muldiv_fire;

  assign load_use = ID_EX_mem_read_in && (ID_EX_RT_in != REG_ZERO) &&
                    ((ID_EX_RT_in == IF_ID_RS_in) ||
                     (IF_ID_uses_rt_in && (ID_EX_RT_in == IF_ID_RT_in)));

  assign muldiv_fire = MULDIV_STALLS && muldiv_start_in;

  // State register
  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      state_q <= RUN;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      RUN: begin
        if (muldiv_fire) begin
          state_d = BUSY;
          cnt_d   = CNT_LOAD;
        end
      end
      BUSY: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          state_d = RUN;
        end
      end
      default: begin
        state_d = RUN;
        cnt_d   = 4'd0;
      end
    endcase
  end

  // Output logic; reset forces the defaults regardless of state
  always_comb begin
    PC_write_out      = 1'b1;
    IF_ID_write_out   = 1'b1;
    ID_EX_write_out   = 1'b1;
    ID_EX_bubble_out  = 1'b0;
    EX_MEM_bubble_out = 1'b0;
    IF_ID_flush_out   = 1'b0;
    ID_EX_flush_out   = 1'b0;
    muldiv_busy_out   = 1'b0;
    if (rst_n_in) begin
      case (state_q)
        RUN: begin
          // Priority: mult/div occupancy, then branch squash, then load-use.
          if (muldiv_fire) begin
            PC_write_out      = 1'b0;
            IF_ID_write_out   = 1'b0;
            ID_EX_write_out   = 1'b0;
            EX_MEM_bubble_out = 1'b1;
          end else if (branch_taken_in) begin
            IF_ID_flush_out = 1'b1;
            ID_EX_flush_out = 1'b1;
          end else if (load_use) begin
            PC_write_out     = 1'b0;
            IF_ID_write_out  = 1'b0;
            ID_EX_bubble_out = 1'b1;
          end
        end
        BUSY: begin
          muldiv_busy_out = 1'b1;
          if (cnt_q != 4'd0) begin
            PC_write_out      = 1'b0;
            IF_ID_write_out   = 1'b0;
            ID_EX_write_out   = 1'b0;
            EX_MEM_bubble_out = 1'b1;
          end
        end
        default: begin
          muldiv_busy_out = 1'b0;
        end
      endcase
    end
  end

  sat_counter #(
    .WIDTH(PERF_WIDTH)
  ) u_stall_cnt (
    .clk_in   (clk_in),
    .rst_n_in (rst_n_in),
    .inc_in   (~PC_write_out),
    .count_out(stall_cycles_out)
  );

endmodule

// File: tb/tb_hazard_stall_controller.sv
// tb/tb_hazard_stall_controller.sv - self-checking bench for hazard_stall_controller

module tb_hazard_stall_controller;

  logic       clk_in = 1'b0;
  logic       rst_n_in;
  logic       mem_read;
  logic [4:0] ex_rt, id_rs, id_rt;
  logic       uses_rt, md_start, br_taken;

  logic a_pc, a_ifid, a_idex, a_idbub, a_exbub, a_iff, a_idf, a_busy;
  logic b_pc, b_ifid, b_idex, b_idbub, b_exbub, b_iff, b_idf, b_busy;
  logic [15:0] a_cnt;
  logic [2:0]  b_cnt;

  always #5 clk_in = ~clk_in;

  hazard_stall_controller dut_a (
    .clk_in           (clk_in),
    .rst_n_in         (rst_n_in),
    .ID_EX_mem_read_in(mem_read),
    .ID_EX_RT_in      (ex_rt),
    .IF_ID_RS_in      (id_rs),
    .IF_ID_RT_in      (id_rt),
    .IF_ID_uses_rt_in (uses_rt),
    .muldiv_start_in  (md_start),
    .branch_taken_in  (br_taken),
    .PC_write_out     (a_pc),
    .IF_ID_write_out  (a_ifid),
    .ID_EX_write_out  (a_idex),
    .ID_EX_bubble_out (a_idbub),
    .EX_MEM_bubble_out(a_exbub),
    .IF_ID_flush_out  (a_iff),
    .ID_EX_flush_out  (a_idf),
    .muldiv_busy_out  (a_busy),
    .stall_cycles_out (a_cnt)
  );

  hazard_stall_controller #(
    .MULDIV_LATENCY(2),
    .PERF_WIDTH    (3)
  ) dut_b (
    .clk_in           (clk_in),
    .rst_n_in         (rst_n_in),
    .ID_EX_mem_read_in(mem_read),
    .ID_EX_RT_in      (ex_rt),
    .IF_ID_RS_in      (id_rs),
    .IF_ID_RT_in      (id_rt),
    .IF_ID_uses_rt_in (uses_rt),
    .muldiv_start_in  (md_start),
    .branch_taken_in  (br_taken),
    .PC_write_out     (b_pc),
    .IF_ID_write_out  (b_ifid),
    .ID_EX_write_out  (b_idex),
    .ID_EX_bubble_out (b_idbub),
    .EX_MEM_bubble_out(b_exbub),
    .IF_ID_flush_out  (b_iff),
    .ID_EX_flush_out  (b_idf),
    .muldiv_busy_out  (b_busy),
    .stall_cycles_out (b_cnt)
  );

  int tests_run    = 0;
  int tests_failed = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference model: a mult/div started at cycle ms occupies EX for cycles
  // ms .. ms+lat-1; the pipe is held for every such cycle except the last,
  // and the controller reports busy for every cycle after the start.
  int cyc     = 0;
  int ms[2]   = '{-100, -100};
  int lat[2]  = '{4, 2};
  int cnt[2]  = '{0, 0};
  int maxc[2] = '{65535, 7};

  // Output vector order: {pc, ifid, idex, idbub, exbub, iff, idf, busy}
  task automatic step(input logic r, input logic m, input logic [4:0] e,
                      input logic [4:0] a, input logic [4:0] b, input logic u,
                      input logic d, input logic bt);
    logic [7:0] exp;
    logic [7:0] got;
    logic [31:0] got_cnt;
    logic lu;
    @(negedge clk_in);
    rst_n_in = r; mem_read = m; ex_rt = e; id_rs = a; id_rt = b;
    uses_rt = u; md_start = d; br_taken = bt;
    #1;
    lu = m && (e != 5'd0) && ((e == a) || (u && (e == b)));
    for (int k = 0; k < 2; k++) begin
      exp = 8'b1110_0000;
      if (!r) begin
        ms[k] = -100;
      end else if (cyc > ms[k] && cyc <= ms[k] + lat[k] - 1) begin
        exp = (cyc < ms[k] + lat[k] - 1) ? 8'b0000_1001 : 8'b1110_0001;
      end else if (d && lat[k] >= 2) begin
        exp = 8'b0000_1000;
        ms[k] = cyc;
      end else if (bt) begin
        exp = 8'b1110_0110;
      end else if (lu) begin
        exp = 8'b0011_0000;
      end
      if (k == 0) begin
        got = {a_pc, a_ifid, a_idex, a_idbub, a_exbub, a_iff, a_idf, a_busy};
        got_cnt = {16'd0, a_cnt};
      end else begin
        got = {b_pc, b_ifid, b_idex, b_idbub, b_exbub, b_iff, b_idf, b_busy};
        got_cnt = {29'd0, b_cnt};
      end
      check($sformatf("outs%0d_c%0d", k, cyc), {24'd0, got}, {24'd0, exp});
      check($sformatf("cnt%0d_c%0d", k, cyc), got_cnt, cnt[k]);
      if (!r) cnt[k] = 0;
      else if (!exp[7] && cnt[k] < maxc[k]) cnt[k]++;
    end
    cyc++;
  endtask

  task automatic idle();
    step(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    rst_n_in = 1'b0; mem_read = 1'b0; ex_rt = 5'd0; id_rs = 5'd0; id_rt = 5'd0;
    uses_rt = 1'b0; md_start = 1'b0; br_taken = 1'b0;
    repeat (2) @(posedge clk_in);

    // Reset state, with hazard inputs active to show they are masked
    step(1'b0, 1'b1, 5'd8, 5'd8, 5'd0, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 5'd8, 5'd8, 5'd0, 1'b0, 1'b0, 1'b0);
    idle();

    // Load-use on RS: single stall
    step(1'b1, 1'b1, 5'd8, 5'd8, 5'd0, 1'b0, 1'b0, 1'b0);
    idle();
    check("lu_cnt", {16'd0, a_cnt}, 32'd1);

    // RT match but RT not used; $0 dependence
    step(1'b1, 1'b1, 5'd8, 5'd3, 5'd8, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0);
    // RT match with RT used
    step(1'b1, 1'b1, 5'd9, 5'd3, 5'd9, 1'b1, 1'b0, 1'b0);
    idle();
    check("lu_rt_cnt", {16'd0, a_cnt}, 32'd2);

    // Mult/div pulse, load-use and branch ignored while busy
    step(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 5'd8, 5'd8, 5'd0, 1'b0, 1'b1, 1'b1);
    idle();
    idle();
    idle();
    check("md_cnt", {16'd0, a_cnt}, 32'd5);

    // Branch together with load-use
    step(1'b1, 1'b1, 5'd8, 5'd8, 5'd0, 1'b0, 1'b0, 1'b1);
    idle();
    check("br_cnt", {16'd0, a_cnt}, 32'd5);

    // Reset in the middle of BUSY
    step(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    idle();
    check("rst_cnt", {16'd0, a_cnt}, 32'd0);
    check("rst_busy", {31'd0, a_busy}, 32'd0);
    idle();

    // Saturation of the 3-bit counter
    for (int i = 0; i < 9; i++) step(1'b1, 1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b0, 1'b0);
    idle();
    check("sat_cnt", {29'd0, b_cnt}, 32'd7);
    check("nosat_cnt", {16'd0, a_cnt}, 32'd9);

    // Randomised traffic over a small register pool to provoke matches
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 59) != 0),
           ($urandom_range(0, 1) == 1),
           5'($urandom_range(0, 3)),
           5'($urandom_range(0, 3)),
           5'($urandom_range(0, 3)),
           ($urandom_range(0, 1) == 1),
           ($urandom_range(0, 9) == 0),
           ($urandom_range(0, 5) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
